// File: rtl/keccak_pad_in_if.sv
// ----------------------------------------------------------------------------
// keccak_pad_in_if
// Purpose : Groups the input (message) and output (core) handshake buses of
//           the Keccak input padder.
// Signals : cmode          - hash mode, taken from the first word of a message
//           in_valid/in_ready, in_data, in_last, in_bytes - message word stream
//           out_valid/out_ready, out_data, out_last_block - padded word stream
// Modports: slave  - the padder itself
//           master - the message source / core side
// ----------------------------------------------------------------------------
interface keccak_pad_in_if;
    logic [2:0]  cmode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last_block;

    modport slave (
        input  cmode, in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_data, out_last_block
    );

    modport master (
        output cmode, in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_data, out_last_block
    );
endinterface

// File: rtl/keccak_pad_in.sv
// ----------------------------------------------------------------------------
// keccak_pad_in
// Purpose : Applies SHA-3 / SHAKE multi-rate padding to a 64-bit little-endian
//           message word stream. The message is forwarded with one register
//           stage; after the last word the domain suffix, zero fill and the
//           final 0x80 byte are generated so every message ends on a whole
//           rate block of R words.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - keccak_pad_in_if.slave (input and output handshakes)
// ----------------------------------------------------------------------------
module keccak_pad_in (
    input  logic                  clk,
    input  logic                  rst_n,
    keccak_pad_in_if.slave        bus
);

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        SUFFIX = 2'd1,
        ZERO   = 2'd2
    } state_t;

    // Rate in 64-bit words for each mode; unused codes fall back to SHA3-256.
    function automatic logic [4:0] rate_words(input logic [2:0] mode);
        case (mode)
            3'd0:    rate_words = 5'd18;
            3'd1:    rate_words = 5'd17;
            3'd2:    rate_words = 5'd13;
            3'd3:    rate_words = 5'd9;
            3'd4:    rate_words = 5'd21;
            3'd5:    rate_words = 5'd17;
            default: rate_words = 5'd17;
        endcase
    endfunction

    // SHAKE modes use the 1111 domain suffix, SHA3 modes use 01.
    function automatic logic [7:0] suffix_byte(input logic [2:0] mode);
        suffix_byte = ((mode == 3'd4) || (mode == 3'd5)) ? 8'h1F : 8'h06;
    endfunction

    state_t      r_state;
    logic [4:0]  r_wc;
    logic [2:0]  r_mode;
    logic        r_in_msg;     // a message is in progress (mode already latched)
    logic        r_run;        // holds in_ready low for the reset cycle
    logic        r_out_valid;
    logic [63:0] r_out_data;
    logic        r_out_last;

    state_t      w_next_state;
    logic [2:0]  w_mode;
    logic [4:0]  w_rate;
    logic        w_wc_end;
    logic [7:0]  w_sfx;
    logic        w_adv;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_gen;
    logic        w_load;
    logic [63:0] w_word;
    logic        w_last_blk;
    logic [4:0]  w_next_wc;

    // The first accepted word of a message uses the live cmode; later words
    // use the copy latched on that first word.
    assign w_mode     = r_in_msg ? r_mode : bus.cmode;
    assign w_rate     = rate_words(w_mode);
    assign w_wc_end   = (r_wc == (w_rate - 5'd1));
    assign w_sfx      = suffix_byte(w_mode);

    // Output register may load when empty or being drained this cycle.
    assign w_adv      = !r_out_valid || bus.out_ready;
    assign w_in_ready = r_run && (r_state == PASS) && w_adv;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_gen      = (r_state != PASS) && w_adv;
    assign w_load     = w_accept || w_gen;

    assign w_next_wc  = (w_last_blk || w_wc_end) ? 5'd0 : (r_wc + 5'd1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_word       = bus.in_data;
        w_last_blk   = 1'b0;
        w_next_state = r_state;

        case (r_state)
            PASS: begin
                if (bus.in_last) begin
                    if (bus.in_bytes < 4'd8) begin
                        // Keep valid bytes, put the suffix right after them,
                        // clear everything above.
                        for (int k = 0; k < 8; k++) begin
                            if (k == int'(bus.in_bytes)) begin
                                w_word[8*k +: 8] = w_sfx;
                            end else if (k > int'(bus.in_bytes)) begin
                                w_word[8*k +: 8] = 8'h00;
                            end
                        end
                        if (w_wc_end) begin
                            w_word[63:56] = w_word[63:56] | 8'h80;
                            w_last_blk    = 1'b1;
                        end else begin
                            w_next_state = ZERO;
                        end
                    end else begin
                        w_next_state = SUFFIX;
                    end
                end
            end

            SUFFIX: begin
                w_word = {56'd0, w_sfx};
                if (w_wc_end) begin
                    w_word[63:56] = 8'h80;
                    w_last_blk    = 1'b1;
                    w_next_state  = PASS;
                end else begin
                    w_next_state = ZERO;
                end
            end

            ZERO: begin
                w_word = 64'd0;
                if (w_wc_end) begin
                    w_word       = 64'h8000_0000_0000_0000;
                    w_last_blk   = 1'b1;
                    w_next_state = PASS;
                end
            end

            default: begin
                w_word       = 64'd0;
                w_next_state = PASS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all control and output state is reset; a reset mid-message
        // drops the partial message and any pending pad words.
        if (!rst_n) begin
            r_state     <= PASS;
            r_wc        <= 5'd0;
            r_mode      <= 3'd0;
            r_in_msg    <= 1'b0;
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 64'd0;
            r_out_last  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values.
            r_run <= 1'b1;
            if (w_load) begin
                r_state     <= w_next_state;
                r_wc        <= w_next_wc;
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_last  <= w_last_blk;
                if (w_last_blk) begin
                    r_in_msg <= 1'b0;
                    r_mode   <= 3'd0;
                end else begin
                    r_in_msg <= 1'b1;
                    r_mode   <= w_mode;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.out_last_block = r_out_last;

endmodule

// File: tb/tb_keccak_pad_in.sv
// ----------------------------------------------------------------------------
// tb_keccak_pad_in
// Purpose : Directed scoreboard bench for keccak_pad_in. Stimulus pushes the
//           hand-computed padded words into a queue; a monitor pops and
//           compares every accepted output word and checks hold behaviour
//           while the output is stalled.
// ----------------------------------------------------------------------------
module tb_keccak_pad_in;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    keccak_pad_in_if bus ();

    keccak_pad_in dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          rnd_ready = 1'b0;
    bit          stalled = 1'b0;
    logic [63:0] held_data;
    logic        held_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        q.push_back(e);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) push(64'd0, 1'b0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send_word(input logic [2:0] mode, input logic [63:0] d,
                             input logic l, input logic [3:0] nb);
        bit acc;
        acc = 1'b0;
        bus.cmode    = mode;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_bytes = nb;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        if (!acc) fail("send_word");
    endtask

    // Wait until every expected word was seen; optionally require in_ready
    // low while generated pad words are still pending.
    task automatic wait_drain(input bit chk_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (chk_ready && !(bus.out_valid && bus.out_last_block))
                check("in_ready_pad", {63'd0, bus.in_ready}, 64'd0);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) fail("drain");
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: always-ready or random stalls
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                    check("hold_data", bus.out_data, held_data);
                    check("hold_last", {63'd0, bus.out_last_block}, {63'd0, held_last});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected none", bus.out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_last", {63'd0, bus.out_last_block}, {63'd0, e.last});
                    end
                end
                stalled   = bus.out_valid && !bus.out_ready;
                held_data = bus.out_data;
                held_last = bus.out_last_block;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmode    = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'd0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 4'd0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_last", {63'd0, bus.out_last_block}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

        // SHA3-256, "abc"
        push(64'h0000_0000_0663_6261, 1'b0);
        push_zeros(15);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd1, 64'h0000_0000_0063_6261, 1'b1, 4'd3);
        wait_drain(1'b1);

        // SHAKE128, empty message; input data must be fully masked
        push(64'h0000_0000_0000_001F, 1'b0);
        push_zeros(19);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd4, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 4'd0);
        wait_drain(1'b1);

        // SHA3-512, 9 full words: block of data then a whole pad block
        for (int i = 0; i < 9; i++) push({8{8'(i + 1)}}, 1'b0);
        push(64'h0000_0000_0000_0006, 1'b0);
        push_zeros(7);
        push(64'h8000_0000_0000_0000, 1'b1);
        for (int i = 0; i < 9; i++)
            send_word(3'd3, {8{8'(i + 1)}}, (i == 8), 4'd8);
        wait_drain(1'b0);

        // SHA3-512, last word 7 bytes at wc=R-1: suffix and 0x80 merge
        for (int i = 0; i < 8; i++) push({8{8'(i + 16)}}, 1'b0);
        push(64'h8622_3344_5566_7788, 1'b1);
        for (int i = 0; i < 8; i++)
            send_word(3'd3, {8{8'(i + 16)}}, 1'b0, 4'd0);
        send_word(3'd3, 64'h1122_3344_5566_7788, 1'b1, 4'd7);
        wait_drain(1'b0);

        // SHA3-224 with random output stalls through the zero fill
        rnd_ready = 1'b1;
        push(64'h0000_06DD_EEFF_0011, 1'b0);
        push_zeros(16);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd0, 64'hAABB_CCDD_EEFF_0011, 1'b1, 4'd5);
        wait_drain(1'b1);
        rnd_ready = 1'b0;

        // Mode 7 behaves as SHA3-256; suffix word lands at wc=1
        push(64'h0123_4567_89AB_CDEF, 1'b0);
        push(64'h0000_0000_0000_0006, 1'b0);
        push_zeros(14);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd7, 64'h0123_4567_89AB_CDEF, 1'b1, 4'd8);
        wait_drain(1'b1);

        // SHAKE256: mode latched on the first word, later cmode ignored
        push(64'hCAFE_BABE_1234_5678, 1'b0);
        push(64'h0000_0000_0000_1FFF, 1'b0);
        push_zeros(14);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd5, 64'hCAFE_BABE_1234_5678, 1'b0, 4'd0);
        send_word(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd1);
        wait_drain(1'b1);

        // Reset at wc=5 of a SHA3-224 message, then a fresh SHA3-384 message
        for (int i = 0; i < 5; i++) push({8{8'(i + 32)}}, 1'b0);
        for (int i = 0; i < 5; i++)
            send_word(3'd0, {8{8'(i + 32)}}, 1'b0, 4'd0);
        wait_drain(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_out_data", bus.out_data, 64'd0);
        check("midrst_out_last", {63'd0, bus.out_last_block}, 64'd0);
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_midrst", {63'd0, bus.in_ready}, 64'd1);
        push(64'h0000_0000_0000_0006, 1'b0);
        push_zeros(11);
        push(64'h8000_0000_0000_0000, 1'b1);
        send_word(3'd2, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 4'd0);
        wait_drain(1'b1);

        // Nothing further may appear on the output
        repeat (10) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keccak_pad_in.md
KECCAK_PAD_IN -- requirements
Module: keccak_pad_in

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmode  input  3  mode, sampled on the first accepted word of a message: 0 SHA3-224 (R=18 words), 1 SHA3-256 (R=17), 2 SHA3-384 (R=13), 3 SHA3-512 (R=9), 4 SHAKE128 (R=21), 5 SHAKE256 (R=17); 6 and 7 behave as 1.
REQ-005 in_valid  input  1  in_data, in_last and in_bytes are valid.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 in_data  input  64  message word, little-endian: byte k = bits[8k+7:8k].
REQ-008 in_last  input  1  this word is the final word of the message.
REQ-009 in_bytes  input  4  count of valid bytes on the in_last word (0..8); ignored otherwise.
REQ-010 out_valid  output  1  out_data is valid toward the core.
REQ-011 out_ready  input  1  core accepts the out_data word.
REQ-012 out_data  output  64  padded word, same byte order as in_data.
REQ-013 out_last_block  output  1  asserted only with the final padded word of the message.

Function
REQ-014 A transfer SHALL occur on any edge where valid and ready are both high; out_valid, out_data and out_last_block SHALL hold while out_valid=1 and out_ready=0.
REQ-015 The output SHALL be a single register stage: in_ready = (state==PASS) && (!out_valid || out_ready); an accepted word appears on out_data the next cycle (latency 1).
REQ-016 State machine states SHALL be PASS, SUFFIX, ZERO.
REQ-017 A word counter wc (0..R-1) SHALL increment on every output word latched and wrap to 0 after R-1; wc and the latched cmode SHALL reset to 0 after the out_last_block word.
REQ-018 Suffix byte SHALL be 0x06 for modes 0-3, 6, 7 and 0x1F for modes 4-5; final pad byte SHALL be 0x80 in byte 7 of word R-1.
REQ-019 PASS, in_last=0: word forwarded unchanged.
REQ-020 PASS, in_last=1, in_bytes<8: bytes >= in_bytes SHALL be zeroed, byte in_bytes SHALL be the suffix; if wc==R-1 byte 7 is additionally ORed with 0x80, out_last_block=1, stay PASS; else go ZERO.
REQ-021 PASS, in_last=1, in_bytes=8: word forwarded unchanged; go SUFFIX.
REQ-022 SUFFIX: emit word with byte 0 = suffix, other bytes 0; if wc==R-1 also OR 0x80 into byte 7, out_last_block=1, go PASS; else go ZERO.
REQ-023 ZERO: emit all-zero words until wc==R-1, then emit 0x8000_0000_0000_0000 with out_last_block=1 and go PASS.
REQ-024 Suffix and 0x80 in the same byte SHALL combine by OR (e.g. 0x86 when in_bytes=7, wc==R-1).
REQ-025 Empty message (in_last=1, in_bytes=0 on the first word) SHALL produce a full padded block starting with byte 0 = suffix.
REQ-026 In SUFFIX and ZERO in_ready SHALL be 0; a generated word SHALL advance only when !out_valid || out_ready.
REQ-027 Total output words per message SHALL be a multiple of R.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, out_last_block=0, in_ready=0, state=PASS, wc=0; in_ready SHALL rise the first cycle after release.
REQ-029 Reset asserted mid-message SHALL discard the partial message; no pad words SHALL be emitted afterwards.

Verification
REQ-030 cmode=1, single word in_last=1, in_bytes=3, data 0x636261 -> word0 = 0x0000_0000_0663_6261, words 1-15 zero, word16 = 0x8000_0000_0000_0000 with out_last_block, 17 words total.
REQ-031 cmode=4, empty message (in_bytes=0) -> word0 = 0x1F, 19 zero words, word20 = 0x8000_0000_0000_0000, out_last_block on word20 only.
REQ-032 cmode=3, 9 words, last with in_bytes=8 -> 9 data words, then SUFFIX word 0x06, 7 zeros, 0x8000_0000_0000_0000; 18 words total.
REQ-033 cmode=3, 9 words, last with in_bytes=7 -> word8 byte7 = 0x86, out_last_block on word8, exactly 9 words.
REQ-034 out_ready toggled randomly during ZERO phase -> no word lost/duplicated, out_data stable while stalled, in_ready=0 until out_last_block word accepted.
REQ-035 rst_n pulsed low at wc=5 of a cmode=0 message -> outputs zero immediately, next message padded from wc=0 with the newly sampled cmode.
